// File: rtl/tshoot_gun_pkg.sv
// Shared types and helpers for the Turkey Shoot gun-position ADC model.
package tshoot_gun_pkg;

  localparam int unsigned GUN_W = 6;
  localparam int unsigned ADC_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } adc_state_t;

  localparam logic [1:0] CH_H = 2'd0;
  localparam logic [1:0] CH_V = 2'd1;

  // Full-scale stretch: replicating the top bits maps 0 -> 8'h00 and 63 -> 8'hFF.
  function automatic logic [ADC_W-1:0] scale6to8(input logic [GUN_W-1:0] v);
    return {v, v[GUN_W-1 -: 2]};
  endfunction

endpackage

// File: rtl/tshoot_adc_timer.sv
// Loadable down-counter that stops at zero; paces one ADC conversion.
module tshoot_adc_timer #(
  parameter int unsigned W = 7
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/tshoot_gun_adc.sv
// Gun-position analog mux + ADC responder polled by the Williams-2 CPU board.
module tshoot_gun_adc
  import tshoot_gun_pkg::*;
#(
  parameter int unsigned      CONV_CYCLES = 100,
  parameter int unsigned      INVERT_V    = 0,
  parameter logic [ADC_W-1:0] UNUSED_CODE = 8'h80
) (
  input  logic             clock_12,
  input  logic             reset,
  input  logic [GUN_W-1:0] gun_h,
  input  logic [GUN_W-1:0] gun_v,
  input  logic [1:0]       adc_sel,
  input  logic             adc_start,
  input  logic             adc_rd,
  output logic [ADC_W-1:0] adc_data,
  output logic             adc_eoc,
  output logic             adc_busy,
  output logic             adc_irq
);

  localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  adc_state_t       r_state;
  adc_state_t       w_state_nxt;
  logic             w_accept;
  logic             w_done;
  logic             w_zero;
  logic [1:0]       r_sel;
  logic [GUN_W-1:0] r_hold;
  logic [ADC_W-1:0] w_result;
  logic [ADC_W-1:0] r_data;
  logic             r_eoc;
  logic             r_busy;
  logic             r_irq;

  tshoot_adc_timer #(
    .W (CNT_W)
  ) u_timer (
    .i_clk      (clock_12),
    .i_reset    (reset),
    .i_load     (w_accept),
    .i_load_val (CNT_W'(CONV_CYCLES - 1)),
    .i_en       (r_state == CONVERT),
    .o_zero_c   (w_zero)
  );

  always_ff @(posedge clock_12) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A start is honoured in every state; it also aborts any pending completion.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (adc_start) begin
          w_accept    = 1'b1;
          w_state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        if (adc_start) begin
          w_accept = 1'b1;
        end else if (w_zero) begin
          w_done      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (adc_start) begin
          w_accept    = 1'b1;
          w_state_nxt = CONVERT;
        end else if (adc_rd) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_result = UNUSED_CODE;
    case (r_sel)
      CH_H:    w_result = scale6to8(r_hold);
      CH_V:    w_result = scale6to8(r_hold) ^ {ADC_W{INVERT_V != 0}};
      default: w_result = UNUSED_CODE;
    endcase
  end

  // Sample-and-hold plus the registered CPU-visible status.
  always_ff @(posedge clock_12) begin
    if (reset) begin
      r_sel  <= CH_H;
      r_hold <= '0;
      r_data <= '0;
      r_eoc  <= 1'b0;
      r_busy <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sel  <= adc_sel;
        r_hold <= (adc_sel == CH_V) ? gun_v : gun_h;
      end
      if (w_done) begin
        r_data <= w_result;
      end
      if (w_done) begin
        r_eoc <= 1'b1;
      end else if (w_accept || ((r_state == DONE) && adc_rd)) begin
        r_eoc <= 1'b0;
      end
      r_busy <= (w_state_nxt == CONVERT);
      r_irq  <= w_done;
    end
  end

  assign adc_data = r_data;
  assign adc_eoc  = r_eoc;
  assign adc_busy = r_busy;
  assign adc_irq  = r_irq;

endmodule
